memory_unit: RTL
================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, MAR and address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory word and bus width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port bus_in  input  DATA_W  CPU bus value seen by this block.
REQ-007 SHALL have port bus_out  output  DATA_W  RAM[MAR] when driving, else 0.
REQ-008 SHALL have port bus_oe  output  1  high while bus_out is driven onto the CPU bus.
REQ-009 SHALL have port nLma  input  1  active-low MAR load from bus_in[ADDR_W-1:0].
REQ-010 SHALL have port nLmd  input  1  active-low write of bus_in into RAM[MAR].
REQ-011 SHALL have port nCE  input  1  active-low RAM output enable.
REQ-012 SHALL have port prog_mode  input  1  selects external programming over CPU control.
REQ-013 SHALL have port prog_valid  input  1  programming word offered.
REQ-014 SHALL have port prog_addr  input  ADDR_W  programming address.
REQ-015 SHALL have port prog_data  input  DATA_W  programming data.
REQ-016 SHALL have port prog_ready  output  1  block can accept a programming word.
REQ-017 SHALL have port busy  output  1  high in CLEAR or PROG_WRITE.
REQ-018 SHALL have port mar  output  ADDR_W  current MAR value, for debug.

Function
REQ-019 SHALL implement an FSM with states CLEAR (only with MEM_CLEAR_EN), RUN, PROG_IDLE and PROG_WRITE.
REQ-020 SHALL, in RUN, sample nLma, nLmd and nCE; in all other states it SHALL ignore them and hold bus_oe=0.
REQ-021 SHALL load MAR on a clk edge with nLma=0 in RUN.
REQ-022 SHALL write bus_in to RAM[MAR] on a clk edge with nLmd=0 in RUN, using the pre-edge MAR.
REQ-023 SHALL, with nLma=0 and nLmd=0 together, write to the old MAR and load the new MAR.
REQ-024 SHALL combinationally drive bus_out=RAM[MAR] and bus_oe=1 when in RUN with nCE=0, with zero latency.
REQ-025 SHALL, with nCE=0 and nLmd=0 together, drive the old word and write the new word at the edge (read-before-write).
REQ-026 SHALL go from RUN to PROG_IDLE on a clk edge with prog_mode=1.
REQ-027 SHALL hold prog_ready=1 only in PROG_IDLE.
REQ-028 SHALL, on prog_valid and prog_ready both high at an edge, capture prog_addr and prog_data and enter PROG_WRITE.
REQ-029 SHALL, in PROG_WRITE, write the captured word on the next edge, then go to PROG_IDLE; one word per 2 cycles.
REQ-030 SHALL go from PROG_IDLE to RUN when prog_mode=0; prog_mode falling in PROG_WRITE completes the write and then goes to RUN.
REQ-031 SHALL leave MAR unchanged by programming.

Reset
REQ-032 SHALL, on rst, clear MAR to 0, bus_oe to 0, bus_out to 0, prog_ready to 0 and the capture registers to 0.
REQ-033 SHALL enter CLEAR after rst if MEM_CLEAR_EN is defined, else RUN.
REQ-034 SHALL abort any in-progress write when rst asserts mid-PROG_WRITE; the target word is then unspecified unless cleared.

Configuration
REQ-035 SHALL, with MEM_CLEAR_EN defined, sweep addresses 0..2^ADDR_W-1 in CLEAR, writing 0 one word per cycle with busy=1, then enter RUN (16 cycles at default).
REQ-036 SHALL, without MEM_CLEAR_EN, have no CLEAR state and leave RAM contents undefined after reset.

Structure
REQ-037 SHALL take ADDR_W/DATA_W defaults and the FSM state enum from shared package cpu_pkg.
REQ-038 SHALL place the storage array in sub-module ram16x8: sync write, async read, 1 write port.

Verification
REQ-039 SHALL test RUN access: nLma=0 with bus=0x03, then nLmd=0 with bus=0xA5, then nCE=0 -> bus_out=0xA5, bus_oe=1.
REQ-040 SHALL test simultaneous control: MAR=2, RAM[2]=0x11; nLma=0, nLmd=0, bus=0x07 -> RAM[2]=0x07, MAR=7.
REQ-041 SHALL test read-before-write: nCE=0, nLmd=0, RAM[MAR]=0x3C, bus_in=0xC3 -> bus_out=0x3C that cycle, 0xC3 next.
REQ-042 SHALL test programming: prog_mode=1, valid with addr=0xF, data=0x5A -> ready low 1 cycle, RAM[15]=0x5A, MAR unchanged.
REQ-043 SHALL test mid-write mode exit: prog_mode falls in PROG_WRITE -> write completes, RUN next, nCE honoured.
REQ-044 SHALL test MEM_CLEAR_EN: after rst, busy high 16 cycles, every address then reads 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus/address widths and memory-unit FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a. ST_CLEAR exists only when MEM_CLEAR_EN is defined.
package cpu_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
`ifdef MEM_CLEAR_EN
        ST_CLEAR      = 2'd0,
`endif
        ST_RUN        = 2'd1,
        ST_PROG_IDLE  = 2'd2,
        ST_PROG_WRITE = 2'd3
    } mem_state_t;

`ifdef MEM_CLEAR_EN
    localparam mem_state_t MEM_RST_STATE = ST_CLEAR;
`else
    localparam mem_state_t MEM_RST_STATE = ST_RUN;
`endif

endpackage

// File: rtl/ram16x8.sv
// Storage array with one synchronous write port and one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none, a write is accepted every cycle we is high.
module ram16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are not reset; clearing is the owner's job.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// CPU RAM + MAR with an external programming port; optional power-up clear under MEM_CLEAR_EN.
// Latency: bus_out follows RAM[MAR] combinationally; CPU writes/MAR loads land on the edge; prog word in 2 cycles.
// Backpressure: prog_ready is high only in PROG_IDLE, so programming accepts at most one word every 2 cycles.
module memory_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              nLma,
    input  logic              nLmd,
    input  logic              nCE,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mar
);

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
`endif

    // State register; reset mid-write simply abandons the captured word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM write-port steering.
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_waddr = mar;
        ram_wdata = bus_in;
        case (state)
`ifdef MEM_CLEAR_EN
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
                if (clr_addr == '1) begin
                    state_nxt = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                // Write uses the pre-edge MAR even when nLma loads a new one.
                ram_we = ~nLmd;
                if (prog_mode) begin
                    state_nxt = ST_PROG_IDLE;
                end
            end
            ST_PROG_IDLE: begin
                // An accepted handshake always completes, even if mode drops on the same edge.
                if (prog_valid) begin
                    state_nxt = ST_PROG_WRITE;
                end else if (!prog_mode) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PROG_WRITE: begin
                ram_we    = 1'b1;
                ram_waddr = cap_addr;
                ram_wdata = cap_data;
                state_nxt = prog_mode ? ST_PROG_IDLE : ST_RUN;
            end
            default: begin
                state_nxt = MEM_RST_STATE;
            end
        endcase
    end

    // MAR loads only under CPU control; programming never touches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar <= '0;
        end else if (state == ST_RUN && !nLma) begin
            mar <= bus_in[ADDR_W-1:0];
        end
    end

    // Capture the programming word on the PROG_IDLE handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if (state == ST_PROG_IDLE && prog_valid) begin
            cap_addr <= prog_addr;
            cap_data <= prog_data;
        end
    end

`ifdef MEM_CLEAR_EN
    // Sweep pointer for the post-reset clear, one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end
`endif

    ram16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mar),
        .rdata (ram_rdata)
    );

    // rst gating keeps the bus released while reset is held, whatever nCE does.
    assign bus_oe     = (state == ST_RUN) && !nCE && !rst;
    assign bus_out    = bus_oe ? ram_rdata : '0;
    assign prog_ready = (state == ST_PROG_IDLE);
    assign busy       = (state == ST_PROG_WRITE)
`ifdef MEM_CLEAR_EN
                        || (state == ST_CLEAR)
`endif
                        ;

endmodule
